// File: rtl/br_update_queue_if.sv
// Bundle between the two branch-resolution lanes and the branch_unit update port.
// master = execute-stage side, slave = br_update_queue.
interface br_update_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_l0_en;
  logic          i_l0_valid;
  logic          i_l0_taken;
  logic [31:0]   i_l0_pc;
  logic [31:0]   i_l0_target;
  logic          i_l1_en;
  logic          i_l1_valid;
  logic          i_l1_taken;
  logic [31:0]   i_l1_pc;
  logic [31:0]   i_l1_target;
  logic          o_br_update_en;
  logic          o_br_update_valid;
  logic          o_br_update_taken;
  logic [31:0]   o_br_update_pc;
  logic [31:0]   o_br_update_target;
  logic          o_ready;
  logic          o_overflow;
  logic [CW-1:0] o_count;

  modport master (
    output i_l0_en, i_l0_valid, i_l0_taken, i_l0_pc, i_l0_target,
    output i_l1_en, i_l1_valid, i_l1_taken, i_l1_pc, i_l1_target,
    input  o_br_update_en, o_br_update_valid, o_br_update_taken,
    input  o_br_update_pc, o_br_update_target, o_ready, o_overflow, o_count
  );

  modport slave (
    input  i_l0_en, i_l0_valid, i_l0_taken, i_l0_pc, i_l0_target,
    input  i_l1_en, i_l1_valid, i_l1_taken, i_l1_pc, i_l1_target,
    output o_br_update_en, o_br_update_valid, o_br_update_taken,
    output o_br_update_pc, o_br_update_target, o_ready, o_overflow, o_count
  );
endinterface

// File: rtl/br_update_queue.sv
// Two-lane in-order branch-resolution queue feeding branch_unit's single update port.
// Optional same-cycle bypass on an empty queue: define BR_UPDATE_BYPASS_EN.
module br_update_queue #(
  parameter int DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  br_update_queue_if.slave   io_brIf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW:0]   ONE_W   = (CW+1)'(1);
  localparam logic [CW:0]   TWO_W   = (CW+1)'(2);
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic          r_valid  [DEPTH];
  logic          r_taken  [DEPTH];
  logic [31:0]   r_pc     [DEPTH];
  logic [31:0]   r_target [DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_pop;
  logic          w_bypass;
  logic          w_store0;
  logic          w_store1;
  logic          w_acc0;
  logic          w_acc1;
  logic          w_drop;
  logic [CW:0]   w_free;
  logic [PW-1:0] w_wrAddr1;

  assign w_pop = (r_count != '0);

`ifdef BR_UPDATE_BYPASS_EN
  assign w_bypass = (r_count == '0) && (io_brIf.i_l0_en || io_brIf.i_l1_en);
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed lane is consumed directly and never takes a storage slot.
  assign w_store0 = io_brIf.i_l0_en && !w_bypass;
  assign w_store1 = io_brIf.i_l1_en && !(w_bypass && !io_brIf.i_l0_en);

  // Slots free at the next edge count the head leaving; lane 0 wins the last slot.
  assign w_free    = DEPTH_W - {1'b0, r_count} + {{CW{1'b0}}, w_pop};
  assign w_acc0    = w_store0 && (w_free >= ONE_W);
  assign w_acc1    = w_store1 && (w_acc0 ? (w_free >= TWO_W) : (w_free >= ONE_W));
  assign w_drop    = (w_store0 && !w_acc0) || (w_store1 && !w_acc1);
  assign w_wrAddr1 = r_wrPtr + PW'(w_acc0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_taken[i]  <= 1'b0;
        r_pc[i]     <= '0;
        r_target[i] <= '0;
      end
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_acc0) begin
        r_valid[r_wrPtr]  <= io_brIf.i_l0_valid;
        r_taken[r_wrPtr]  <= io_brIf.i_l0_taken;
        r_pc[r_wrPtr]     <= io_brIf.i_l0_pc;
        r_target[r_wrPtr] <= io_brIf.i_l0_target;
      end
      if (w_acc1) begin
        r_valid[w_wrAddr1]  <= io_brIf.i_l1_valid;
        r_taken[w_wrAddr1]  <= io_brIf.i_l1_taken;
        r_pc[w_wrAddr1]     <= io_brIf.i_l1_pc;
        r_target[w_wrAddr1] <= io_brIf.i_l1_target;
      end
      r_wrPtr <= r_wrPtr + PW'(w_acc0) + PW'(w_acc1);
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      r_count <= r_count + CW'(w_acc0) + CW'(w_acc1) - CW'(w_pop);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    io_brIf.o_br_update_en     = 1'b0;
    io_brIf.o_br_update_valid  = 1'b0;
    io_brIf.o_br_update_taken  = 1'b0;
    io_brIf.o_br_update_pc     = '0;
    io_brIf.o_br_update_target = '0;
    if (w_bypass) begin
      io_brIf.o_br_update_en = 1'b1;
      if (io_brIf.i_l0_en) begin
        io_brIf.o_br_update_valid  = io_brIf.i_l0_valid;
        io_brIf.o_br_update_taken  = io_brIf.i_l0_taken;
        io_brIf.o_br_update_pc     = io_brIf.i_l0_pc;
        io_brIf.o_br_update_target = io_brIf.i_l0_target;
      end else begin
        io_brIf.o_br_update_valid  = io_brIf.i_l1_valid;
        io_brIf.o_br_update_taken  = io_brIf.i_l1_taken;
        io_brIf.o_br_update_pc     = io_brIf.i_l1_pc;
        io_brIf.o_br_update_target = io_brIf.i_l1_target;
      end
    end else if (w_pop) begin
      io_brIf.o_br_update_en     = 1'b1;
      io_brIf.o_br_update_valid  = r_valid[r_rdPtr];
      io_brIf.o_br_update_taken  = r_taken[r_rdPtr];
      io_brIf.o_br_update_pc     = r_pc[r_rdPtr];
      io_brIf.o_br_update_target = r_target[r_rdPtr];
    end
  end

  assign io_brIf.o_ready    = (r_count <= READY_MAX);
  assign io_brIf.o_overflow = r_overflow;
  assign io_brIf.o_count    = r_count;

endmodule

// File: tb/tb_br_update_queue.sv
// Directed scoreboard bench for br_update_queue (default build, DEPTH=4).
// Expected head entries are queued when lanes push and compared as the DUT retires them.
module tb_br_update_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] pc;
    logic [31:0] target;
  } entry_t;

  logic   clk = 1'b0;
  logic   rstN;
  entry_t sbQueue[$];
  logic   modelOverflow = 1'b0;
  int     errors = 0;
  int     checks = 0;

  always #5 clk = ~clk;

  br_update_queue_if #(.DEPTH(DEPTH)) brIf ();

  br_update_queue #(.DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .io_brIf (brIf.slave)
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compares every DUT output against the scoreboard head and model state.
  task automatic checkOutput();
    entry_t head;
    int     sz;
    sz = sbQueue.size();
    head = '0;
    if (sz != 0) head = sbQueue[0];
    checkEq("en",       32'(brIf.o_br_update_en),     32'(sz != 0));
    checkEq("valid",    32'(brIf.o_br_update_valid),  32'(head.valid));
    checkEq("taken",    32'(brIf.o_br_update_taken),  32'(head.taken));
    checkEq("pc",       brIf.o_br_update_pc,          head.pc);
    checkEq("target",   brIf.o_br_update_target,      head.target);
    checkEq("count",    32'(brIf.o_count),            32'(sz));
    checkEq("ready",    32'(brIf.o_ready),            32'(sz <= DEPTH - 2));
    checkEq("overflow", 32'(brIf.o_overflow),         32'(modelOverflow));
  endtask

  // Drives both lanes for the coming edge and advances the scoreboard to match.
  task automatic applyStimulus(
    input logic l0En, input logic l0Valid, input logic l0Taken,
    input logic [31:0] l0Pc, input logic [31:0] l0Target,
    input logic l1En, input logic l1Valid, input logic l1Taken,
    input logic [31:0] l1Pc, input logic [31:0] l1Target);
    int free;
    brIf.i_l0_en = l0En;  brIf.i_l0_valid = l0Valid; brIf.i_l0_taken = l0Taken;
    brIf.i_l0_pc = l0Pc;  brIf.i_l0_target = l0Target;
    brIf.i_l1_en = l1En;  brIf.i_l1_valid = l1Valid; brIf.i_l1_taken = l1Taken;
    brIf.i_l1_pc = l1Pc;  brIf.i_l1_target = l1Target;
    if (rstN) begin
      free = DEPTH - sbQueue.size();
      if (sbQueue.size() != 0) begin
        void'(sbQueue.pop_front());
        free++;
      end
      if (l0En) begin
        if (free >= 1) begin
          sbQueue.push_back({l0Valid, l0Taken, l0Pc, l0Target});
          free--;
        end else modelOverflow = 1'b1;
      end
      if (l1En) begin
        if (free >= 1) sbQueue.push_back({l1Valid, l1Taken, l1Pc, l1Target});
        else modelOverflow = 1'b1;
      end
    end
  endtask

  task automatic cycle(
    input logic l0En, input logic [31:0] l0Pc,
    input logic l1En, input logic [31:0] l1Pc);
    @(negedge clk);
    checkOutput();
    applyStimulus(l0En, 1'b1, l0Pc[2], l0Pc, l0Pc + 32'h1000,
                  l1En, 1'b1, l1Pc[2], l1Pc, l1Pc + 32'h1000);
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && sbQueue.size() != 0; i++) idle();
    idle();
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    $display("[TB] reset state");
    checkOutput();
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    $display("[TB] single lane 0 push");
    @(negedge clk);
    checkOutput();
    applyStimulus(1, 1, 1, 32'h100, 32'h200, 0, 0, 0, 0, 0);
    idle();
    idle();

    $display("[TB] dual push program order");
    cycle(1'b1, 32'h10, 1'b1, 32'h14);
    idle();
    idle();
    idle();

    $display("[TB] lane 1 invalid entry");
    @(negedge clk);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 32'h300, 32'h340);
    idle();
    idle();

    $display("[TB] wrap-around single pushes");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h400 + 32'(4 * i), 1'b0, 32'h0);
      idle();
    end
    idle();

    $display("[TB] reset mid-run");
    cycle(1'b1, 32'h500, 1'b1, 32'h504);
    cycle(1'b1, 32'h508, 1'b1, 32'h50C);
    @(negedge clk);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rstN = 1'b0;
    #1;
    checkEq("rstEn",    32'(brIf.o_br_update_en), 32'h0);
    checkEq("rstCount", 32'(brIf.o_count),        32'h0);
    checkEq("rstReady", 32'(brIf.o_ready),        32'h1);
    sbQueue.delete();
    modelOverflow = 1'b0;
    idle();
    @(negedge clk);
    rstN = 1'b1;
    idle();
    idle();

    $display("[TB] sustained dual push ignoring ready");
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'h20 + 32'(8 * i), 1'b1, 32'h24 + 32'(8 * i));
    end
    drain();
    idle();

    $display("[TB] final reset clears overflow");
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkEq("rstOverflow", 32'(brIf.o_overflow), 32'h0);
    checkEq("rstEnFinal",  32'(brIf.o_br_update_en), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded time bound");
    $fatal(1, "[TB] timeout");
  end

endmodule
